// File: rtl/lbp_pkg.sv
// lbp_pkg: shared types and helpers for the LBP scan controller.
//   - lbp_state_t   : controller FSM state encoding
//   - clog2_min1    : ceil(log2(n)), never below 1 (safe register width)
//   - win_radius / n_centre / n_border : geometry helpers for any configuration
//   - R, N_CENTRE, N_BORDER : geometry of the default 128x128, 3x3 configuration
//   - pix_addr      : raster address row*img_w + col
package lbp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CALC,
        S_WRITE,
        S_SHIFT,
        S_COL,
        S_BORDER,
        S_DONE
    } lbp_state_t;

    function automatic int clog2_min1(input int n);
        int v;
        v = 0;
        while ((1 << v) < n) v++;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int win_radius(input int win);
        return win / 2;
    endfunction

    function automatic int n_centre(input int w, input int h, input int win);
        return (w - 2 * win_radius(win)) * (h - 2 * win_radius(win));
    endfunction

    function automatic int n_border(input int w, input int h, input int win);
        return w * h - n_centre(w, h, win);
    endfunction

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_WIN   = 3;
    localparam int R         = win_radius(DEF_WIN);
    localparam int N_CENTRE  = n_centre(DEF_IMG_W, DEF_IMG_H, DEF_WIN);
    localparam int N_BORDER  = n_border(DEF_IMG_W, DEF_IMG_H, DEF_WIN);

    function automatic int pix_addr(input int row, input int col, input int img_w);
        return row * img_w + col;
    endfunction

endpackage

// File: rtl/lbp_scan_counter.sv
// lbp_scan_counter: position bookkeeping for the LBP scan.
//   clk, reset (async, active-high)
//   win_step    : advance intra-window counter (r inner, c outer)
//   win_clr     : clear r/c (wins over win_step)
//   centre_step : advance centre in raster order, wrapping x at row end
//   x, y        : current centre
//   r, c        : current window row/column
//   r_last, c_last       : terminal counts of r and c
//   row_end, last_centre : centre at right edge / final interior centre
module lbp_scan_counter
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int WIN   = 3,
    parameter int XW    = 7,
    parameter int YW    = 7,
    parameter int WW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          win_step,
    input  logic          win_clr,
    input  logic          centre_step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [WW-1:0] r,
    output logic [WW-1:0] c,
    output logic          r_last,
    output logic          c_last,
    output logic          row_end,
    output logic          last_centre
);
    localparam int RAD = win_radius(WIN);
    localparam logic [XW-1:0] X_FIRST = XW'(RAD);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1 - RAD);
    localparam logic [YW-1:0] Y_FIRST = YW'(RAD);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1 - RAD);
    localparam logic [WW-1:0] W_LAST  = WW'(WIN - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [WW-1:0] r_q, r_d;
    logic [WW-1:0] c_q, c_d;

    assign r_last      = (r_q == W_LAST);
    assign c_last      = (c_q == W_LAST);
    assign row_end     = (x_q == X_LAST);
    assign last_centre = row_end && (y_q == Y_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        r_d = r_q;
        c_d = c_q;
        if (win_clr) begin
            r_d = '0;
            c_d = '0;
        end else if (win_step) begin
            if (r_last) begin
                r_d = '0;
                c_d = c_last ? '0 : c_q + WW'(1);
            end else begin
                r_d = r_q + WW'(1);
            end
        end
        // The controller never steps past the last centre, so y cannot overflow.
        if (centre_step) begin
            if (row_end) begin
                x_d = X_FIRST;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= X_FIRST;
            y_q <= Y_FIRST;
            r_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign x = x_q;
    assign y = y_q;
    assign r = r_q;
    assign c = c_q;

endmodule

// File: rtl/lbp_window_ctrl.sv
// lbp_window_ctrl: raster scan controller for the LBP engine.
// Walks all interior centres of an IMG_W x IMG_H image, loads the WIN x WIN
// window (full column-major fill at row start, one new column per step
// afterwards), pulses the compute phase and writes one result per centre.
// Ports:
//   clk, reset (async, active-high)
//   gray_ready in  : image available, starts the scan from IDLE
//   gray_req/gray_addr out : pixel read (data valid same cycle)
//   win_we/win_row/win_col out : window capture strobe and position
//   win_shift out  : shift window one column left
//   calc_en out    : datapath compute enable
//   lbp_valid/lbp_addr out, lbp_ready in : result write handshake
//   lbp_zero out   : border zero write (LBP_BORDER_EN builds only)
//   finish out     : scan complete, held until reset
// Optional feature macro: LBP_BORDER_EN (zero-writes every border pixel
// after the last interior centre).
module lbp_window_ctrl
    import lbp_pkg::*;
#(
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int WIN      = 3,
    parameter int CALC_CYC = 1,
    parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gray_ready,
    output logic                    gray_req,
    output logic [ADDR_W-1:0]       gray_addr,
    output logic                    win_we,
    output logic [$clog2(WIN)-1:0]  win_row,
    output logic [$clog2(WIN)-1:0]  win_col,
    output logic                    win_shift,
    output logic                    calc_en,
    output logic                    lbp_valid,
    input  logic                    lbp_ready,
    output logic [ADDR_W-1:0]       lbp_addr,
    output logic                    lbp_zero,
    output logic                    finish
);
    localparam int RAD = win_radius(WIN);
    localparam int XW  = clog2_min1(IMG_W);
    localparam int YW  = clog2_min1(IMG_H);
    localparam int WW  = $clog2(WIN);
    localparam int CW  = clog2_min1(CALC_CYC);

    lbp_state_t    state_q, state_d;
    logic [CW-1:0] calc_cnt_q, calc_cnt_d;
    logic          finish_q, finish_d;

    logic          win_step, win_clr, centre_step;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [WW-1:0] r, c;
    logic          r_last, c_last, row_end, last_centre;

    lbp_scan_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .XW    (XW),
        .YW    (YW),
        .WW    (WW)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .win_step    (win_step),
        .win_clr     (win_clr),
        .centre_step (centre_step),
        .x           (x),
        .y           (y),
        .r           (r),
        .c           (c),
        .r_last      (r_last),
        .c_last      (c_last),
        .row_end     (row_end),
        .last_centre (last_centre)
    );

`ifdef LBP_BORDER_EN
    // Border walk covers every pixel address; interior pixels are skipped
    // in a single cycle each without raising lbp_valid.
    logic [XW-1:0]     bx_q, bx_d;
    logic [YW-1:0]     by_q, by_d;
    logic [ADDR_W-1:0] ba_q, ba_d;
    logic              b_is_border;

    assign b_is_border = (int'(bx_q) < RAD) || (int'(bx_q) > IMG_W - 1 - RAD) ||
                         (int'(by_q) < RAD) || (int'(by_q) > IMG_H - 1 - RAD);
`endif

    always_comb begin
        state_d     = state_q;
        calc_cnt_d  = calc_cnt_q;
        win_step    = 1'b0;
        win_clr     = 1'b0;
        centre_step = 1'b0;
`ifdef LBP_BORDER_EN
        bx_d = bx_q;
        by_d = by_q;
        ba_d = ba_q;
`endif
        case (state_q)
            S_IDLE: if (gray_ready) state_d = S_FILL;
            S_FILL: begin
                win_step = 1'b1;
                if (r_last && c_last) begin
                    win_clr = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (calc_cnt_q == CW'(CALC_CYC - 1)) begin
                    calc_cnt_d = '0;
                    state_d    = S_WRITE;
                end else begin
                    calc_cnt_d = calc_cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (lbp_ready) begin
                    if (last_centre) begin
`ifdef LBP_BORDER_EN
                        state_d = S_BORDER;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        centre_step = 1'b1;
                        // With IMG_W == WIN every centre is a row end, so only FILL is used.
                        state_d = row_end ? S_FILL : S_SHIFT;
                    end
                end
            end
            S_SHIFT: state_d = S_COL;
            S_COL: begin
                // Only r walks here; clearing on the last row keeps c at 0.
                win_step = 1'b1;
                if (r_last) begin
                    win_clr = 1'b1;
                    state_d = S_CALC;
                end
            end
`ifdef LBP_BORDER_EN
            S_BORDER: begin
                if (!b_is_border || lbp_ready) begin
                    if (ba_q == ADDR_W'(IMG_W * IMG_H - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        ba_d = ba_q + ADDR_W'(1);
                        if (bx_q == XW'(IMG_W - 1)) begin
                            bx_d = '0;
                            by_d = by_q + YW'(1);
                        end else begin
                            bx_d = bx_q + XW'(1);
                        end
                    end
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            default: state_d = state_q;
        endcase
        finish_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            calc_cnt_q <= '0;
            finish_q   <= 1'b0;
`ifdef LBP_BORDER_EN
            bx_q <= '0;
            by_q <= '0;
            ba_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            calc_cnt_q <= calc_cnt_d;
            finish_q   <= finish_d;
`ifdef LBP_BORDER_EN
            bx_q <= bx_d;
            by_q <= by_d;
            ba_q <= ba_d;
`endif
        end
    end

    // Output decode from registered state and counters only.
    assign gray_req  = (state_q == S_FILL) || (state_q == S_COL);
    assign win_we    = gray_req;
    assign win_shift = (state_q == S_SHIFT);
    assign calc_en   = (state_q == S_CALC);
    assign finish    = finish_q;

    always_comb begin
        gray_addr = '0;
        win_row   = '0;
        win_col   = '0;
        if (state_q == S_FILL) begin
            gray_addr = ADDR_W'(pix_addr(int'(y) - RAD + int'(r), int'(x) - RAD + int'(c), IMG_W));
            win_row   = r;
            win_col   = c;
        end else if (state_q == S_COL) begin
            gray_addr = ADDR_W'(pix_addr(int'(y) - RAD + int'(r), int'(x) + RAD, IMG_W));
            win_row   = r;
            win_col   = WW'(WIN - 1);
        end
    end

    always_comb begin
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_zero  = 1'b0;
        if (state_q == S_WRITE) begin
            lbp_valid = 1'b1;
            lbp_addr  = ADDR_W'(pix_addr(int'(y), int'(x), IMG_W));
        end
`ifdef LBP_BORDER_EN
        else if (state_q == S_BORDER && b_is_border) begin
            lbp_valid = 1'b1;
            lbp_addr  = ba_q;
            lbp_zero  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_lbp_window_ctrl.sv
// tb_lbp_window_ctrl: scoreboard bench for lbp_window_ctrl at 8x8, 3x3 window.
// Expected read and write transactions are queued when the scan is started;
// a monitor pops and compares whenever the DUT presents a read or a write.
module tb_lbp_window_ctrl;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WN = 3;
    localparam int CC = 1;
    localparam int AW = 6;
    localparam int RR = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gray_ready = 1'b0;
    logic          lbp_ready = 1'b0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          win_we;
    logic [1:0]    win_row;
    logic [1:0]    win_col;
    logic          win_shift;
    logic          calc_en;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic          lbp_zero;
    logic          finish;

    lbp_window_ctrl #(
        .IMG_W    (W),
        .IMG_H    (H),
        .WIN      (WN),
        .CALC_CYC (CC),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .win_we     (win_we),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_shift  (win_shift),
        .calc_en    (calc_en),
        .lbp_valid  (lbp_valid),
        .lbp_ready  (lbp_ready),
        .lbp_addr   (lbp_addr),
        .lbp_zero   (lbp_zero),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int row; int col;} gexp_t;
    typedef struct {int addr; int zero;} lexp_t;
    gexp_t gq[$];
    lexp_t lq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int g_idx = 0, l_idx = 0, calc_seen = 0, shift_seen = 0;
    int first_req_cyc = -1, first_val_cyc = -1, last_xfer_cyc = -1, finish_cyc = -1;

    int dir_g[12]    = '{0, 8, 16, 1, 9, 17, 2, 10, 18, 3, 11, 19};
    int dir_row2[9]  = '{8, 16, 24, 9, 17, 25, 10, 18, 26};
    int dir_l_idx[5] = '{0, 1, 5, 6, 35};
    int dir_l_val[5] = '{9, 10, 14, 17, 54};

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int all_outs();
        return int'({gray_req, gray_addr, win_we, win_row, win_col, win_shift,
                     calc_en, lbp_valid, lbp_addr, lbp_zero, finish});
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (gray_req) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (gq.size() == 0) begin
                    chk("gray_unexpected", 1, 0);
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    chk("gray_addr", int'(gray_addr), e.addr);
                    chk("win_row", int'(win_row), e.row);
                    chk("win_col", int'(win_col), e.col);
                    chk("win_we", int'(win_we), 1);
                end
                if (g_idx < 12) chk("dir_gray_addr", int'(gray_addr), dir_g[g_idx]);
                if (g_idx >= 24 && g_idx < 33) chk("dir_row2_addr", int'(gray_addr), dir_row2[g_idx - 24]);
                chk("req_with_valid", int'(lbp_valid), 0);
                chk("req_after_finish", int'(finish), 0);
                g_idx++;
            end
            if (calc_en) calc_seen++;
            if (win_shift) shift_seen++;
            if (lbp_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (lbp_valid && lbp_ready) begin
                $display("write %0d: addr=%0d zero=%0d cycle=%0d", l_idx, lbp_addr, lbp_zero, cyc);
                if (lq.size() == 0) begin
                    chk("lbp_unexpected", 1, 0);
                end else begin
                    lexp_t e;
                    e = lq.pop_front();
                    chk("lbp_addr", int'(lbp_addr), e.addr);
                    chk("lbp_zero", int'(lbp_zero), e.zero);
                end
                for (int k = 0; k < 5; k++)
                    if (dir_l_idx[k] == l_idx) chk("dir_lbp_addr", int'(lbp_addr), dir_l_val[k]);
                last_xfer_cyc = cyc;
                l_idx++;
            end
            if (finish && finish_cyc < 0) finish_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        int n_writes;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_outs(), 0);

        // Asynchronous reset in the 5th FILL cycle
        @(posedge clk); #2 gray_ready = 1'b1;
        @(posedge clk); #2 gray_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(negedge clk);
            if (gray_req) n++;
        end
        chk("fill5_reached", n, 5);
        chk("fill5_addr", int'(gray_addr), 9);
        #1 reset = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 0);
        @(posedge clk); @(posedge clk); #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", int'(gray_req), 0);

        // Full scan: build expectations, then start
        for (int y = RR; y <= H - 1 - RR; y++) begin
            for (int x = RR; x <= W - 1 - RR; x++) begin
                if (x == RR) begin
                    for (int c = 0; c < WN; c++)
                        for (int r = 0; r < WN; r++)
                            gq.push_back('{(y - RR + r) * W + (x - RR + c), r, c});
                end else begin
                    for (int r = 0; r < WN; r++)
                        gq.push_back('{(y - RR + r) * W + (x + RR), r, WN - 1});
                end
                lq.push_back('{y * W + x, 0});
            end
        end
        n_writes = 36;
`ifdef LBP_BORDER_EN
        for (int a = 0; a < W * H; a++) begin
            if ((a % W) < RR || (a % W) > W - 1 - RR || (a / W) < RR || (a / W) > H - 1 - RR)
                lq.push_back('{a, 1});
        end
        n_writes = 36 + 28;
`endif
        mon_en = 1'b1;
        lbp_ready = 1'b0;
        @(posedge clk); #2 gray_ready = 1'b1;
        @(posedge clk); #2 gray_ready = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (lbp_valid) seen = 1'b1;
        end
        chk("first_valid_seen", int'(seen), 1);

        // Stall the first write for 5 edges
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", int'(lbp_valid), 1);
            chk("stall_addr", int'(lbp_addr), 9);
            chk("stall_no_req", int'(gray_req), 0);
        end
        @(posedge clk); #2 lbp_ready = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk);
            #2 lbp_ready = ((cyc % 5) != 2);
            if (finish) seen = 1'b1;
        end
        chk("finish_seen", int'(seen), 1);
        lbp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("finish_held", int'(finish), 1);
            chk("no_req_when_done", int'(gray_req), 0);
            chk("no_valid_when_done", int'(lbp_valid), 0);
        end

        chk("gray_queue_empty", gq.size(), 0);
        chk("lbp_queue_empty", lq.size(), 0);
        chk("write_count", l_idx, n_writes);
        chk("read_count", g_idx, 6 * 9 + 30 * 3);
        chk("calc_cycles", calc_seen, 36 * CC);
        chk("shift_cycles", shift_seen, 30);
        chk("fill_to_write_latency", first_val_cyc - first_req_cyc, WN * WN + CC);
        chk("finish_delay", finish_cyc - last_xfer_cyc, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lbp_window_ctrl.md
Name: lbp_window_ctrl

Overview:
Parametrised scan controller for the LBP engine.
- Walks every interior centre of an IMG_W x IMG_H grey image in raster order.
- Loads a WIN x WIN neighbourhood into the datapath window register. A full load happens at the start of each row; afterwards only one new column is fetched per step.
- Sequences the compute phase, then issues one LBP write per centre with a valid/ready handshake.
- Sits between the grey-image memory interface, the LBP datapath and the LBP result memory.

Parameters:
- IMG_W, 128: image width in pixels (>= WIN).
- IMG_H, 128: image height in pixels (>= WIN).
- WIN, 3: window edge length, odd, >= 3. R = WIN/2.
- CALC_CYC, 1: compute cycles per centre (>= 1).
- ADDR_W, $clog2(IMG_W*IMG_H): pixel address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- gray_ready  in  1  image available; starts the scan from IDLE
- gray_req  out  1  read strobe; gray_data is valid in the same cycle
- gray_addr  out  ADDR_W  read address, row*IMG_W + col
- win_we  out  1  datapath captures gray_data into window[win_row][win_col] at this edge
- win_row  out  $clog2(WIN)  window row index
- win_col  out  $clog2(WIN)  window column index
- win_shift  out  1  datapath shifts the window one column left (column 0 dropped)
- calc_en  out  1  datapath compute enable
- lbp_valid  out  1  result write request
- lbp_ready  in  1  result sink accepts the write
- lbp_addr  out  ADDR_W  centre address, y*IMG_W + x
- lbp_zero  out  1  border write of value 0 (LBP_BORDER_EN only; tied 0 otherwise)
- finish  out  1  scan complete; held until reset

Behaviour:
- Reset: all outputs 0. State IDLE. Centre (x,y) = (R,R). All counters 0.
- States: IDLE, FILL, CALC, WRITE, SHIFT, COL, BORDER (macro only), DONE.
- IDLE: gray_ready=1 -> FILL. gray_ready is ignored in all other states.
- FILL, WIN*WIN cycles, column-major:
  - c = 0..WIN-1 outer loop, r = 0..WIN-1 inner loop.
  - gray_req = win_we = 1. win_row = r, win_col = c.
  - gray_addr = (y-R+r)*IMG_W + (x-R+c).
  - Exit -> CALC.
- CALC: calc_en = 1 for CALC_CYC cycles -> WRITE.
- WRITE:
  - lbp_valid = 1; lbp_addr = centre address.
  - lbp_valid and lbp_addr are held stable until lbp_ready = 1; the transfer occurs on that edge.
  - After the transfer:
    - last centre (x = IMG_W-1-R, y = IMG_H-1-R) -> DONE, or BORDER if the macro is defined;
    - else if x = IMG_W-1-R: x <= R, y <= y+1 -> FILL;
    - else x <= x+1 -> SHIFT.
- SHIFT: win_shift = 1 for one cycle -> COL.
- COL: WIN cycles, r = 0..WIN-1, win_col = WIN-1, gray_addr = (y-R+r)*IMG_W + (x+R) -> CALC.
- DONE: finish is registered; it rises one cycle after DONE is entered and stays high until reset. No further requests are issued.
- Outputs gray_req, win_*, calc_en, lbp_valid and lbp_addr are decoded from registered state and counters, so they are glitch-free.
- Asynchronous reset mid-scan: immediate return to reset values. No partial write is ever completed.
- IMG_W = WIN: no SHIFT/COL phases; every row uses FILL.
- Per-centre cost: FILL path WIN*WIN + CALC_CYC + 1 cycles; shift path 1 + WIN + CALC_CYC + 1 cycles, plus any stall cycles.

Optional Feature:
- Macro: LBP_BORDER_EN.
- Defined: after the last interior write, state BORDER visits every non-interior pixel in ascending address order, i.e. pixels with x < R, x > IMG_W-1-R, y < R or y > IMG_H-1-R.
  - Each visit issues lbp_valid = 1, lbp_zero = 1, lbp_addr = that pixel, with the same handshake as WRITE.
  - Number of writes: IMG_W*IMG_H - (IMG_W-2R)*(IMG_H-2R). Then -> DONE.
- Undefined: BORDER state and its address counter are absent; lbp_zero is constant 0.

Decomposition:
- Package lbp_pkg:
  - state enum;
  - constant function clog2_min1;
  - localparams R, N_CENTRE, N_BORDER;
  - address helper function pix_addr(row, col).
- Sub-module lbp_scan_counter:
  - centre x/y registers with row wrap and last-centre flag;
  - intra-window r/c counter with terminal-count outputs;
  - instantiated once; the FSM drives its step/clear inputs.

Test Plan:
- W=H=8, WIN=3, CALC_CYC=1; gray_ready pulsed -> FILL addresses 0,8,16,1,9,17,2,10,18; calc_en 1 cycle; lbp_addr = 9 at cycle 11 after FILL entry.
- Same config, second centre -> win_shift 1 cycle, then COL addresses 3,11,19 with win_col=2; lbp_addr = 10.
- Row wrap after lbp_addr = 14 -> FILL with addresses 8,16,24,9,17,25,10,18,26; next lbp_addr = 17; whole scan gives 36 writes, last 54; finish = 1 one cycle after DONE and held.
- lbp_ready held 0 for 5 cycles at first WRITE -> lbp_valid = 1 with lbp_addr = 9 stable throughout; no gray_req; exactly one transfer.
- Reset asserted in 5th FILL cycle -> all outputs 0 immediately; a fresh gray_ready restarts at address 0.
- LBP_BORDER_EN, W=H=8 -> after address 54: 28 writes with lbp_zero = 1 at addresses 0..8, 15, 16, 23, ..., 55..63; then finish.
